i2s_frame_ctrl: RTL and testbench

I2S_FRAME_CTRL -- requirements
Module: i2s_frame_ctrl

---
 rtl/i2s_frame_ctrl.sv | 145 ++++++++++++++
 tb/tb_i2s_frame_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_ctrl.sv
// I2S bus master framing: bit clock / word select generation with a graceful stop,
// plus a single-entry frame holding register with overrun counting.
module i2s_frame_ctrl #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned HALF_DIV = 4,
    parameter int unsigned OVR_W    = 8
) (
    input  logic                     sclk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    output logic                     bclk_o,
    output logic                     ws_o,
    output logic                     bclkRise_o,
    output logic [$clog2(WIDTH)-1:0] bitIdx_o,
    output logic                     running_o,
    input  logic                     frameStrobe_i,
    input  logic [WIDTH-1:0]         left_i,
    input  logic [WIDTH-1:0]         right_i,
    output logic                     sampleValid_o,
    input  logic                     sampleReady_i,
    output logic [WIDTH-1:0]         leftSample_o,
    output logic [WIDTH-1:0]         rightSample_o,
    output logic [OVR_W-1:0]         overrun_o,
    input  logic                     clrOvr_i
);
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(HALF_DIV - 1);
    localparam logic [OVR_W-1:0] OVR_MAX = '1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bclk_q, bclk_d;
    logic             ws_q, ws_d;
    logic             rise_q, rise_d;
    logic             div_wrap, frame_end;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] right_q, right_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             take, drop;

    assign div_wrap  = (div_q == DIV_MAX);
    // Falling bclk edge that closes the right slot: the only legal place to stop.
    assign frame_end = div_wrap && bclk_q && (idx_q == IDX_MAX) && ws_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bclk_d  = bclk_q;
        ws_d    = ws_q;
        idx_d   = idx_q;
        case (state_q)
            ST_RUN, ST_STOP: begin
                if (div_wrap) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    if (bclk_q) begin
                        if (idx_q == IDX_MAX) begin
                            idx_d = '0;
                            ws_d  = ~ws_q;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                if (state_q == ST_RUN) begin
                    if (!en_i) state_d = ST_STOP;
                end else if (en_i) begin
                    state_d = ST_RUN;
                end else if (frame_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                div_d   = '0;
                bclk_d  = 1'b0;
                ws_d    = 1'b0;
                idx_d   = '0;
                state_d = en_i ? ST_RUN : ST_IDLE;
            end
        endcase
        rise_d = ~bclk_q & bclk_d;
    end

    always_comb begin
        take    = frameStrobe_i && (!valid_q || sampleReady_i);
        drop    = frameStrobe_i && valid_q && !sampleReady_i;
        valid_d = take ? 1'b1 : (sampleReady_i ? 1'b0 : valid_q);
        left_d  = take ? left_i : left_q;
        right_d = take ? right_i : right_q;
        ovr_d   = ovr_q;
        if (clrOvr_i) begin
            ovr_d = '0;
        end else if (drop && (ovr_q != OVR_MAX)) begin
            ovr_d = ovr_q + OVR_W'(1);
        end
    end

    always_ff @(posedge sclk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            bclk_q  <= 1'b0;
            ws_q    <= 1'b0;
            rise_q  <= 1'b0;
            valid_q <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            bclk_q  <= bclk_d;
            ws_q    <= ws_d;
            rise_q  <= rise_d;
            valid_q <= valid_d;
            left_q  <= left_d;
            right_q <= right_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bclk_o        = bclk_q;
    assign ws_o          = ws_q;
    assign bclkRise_o    = rise_q;
    assign bitIdx_o      = idx_q;
    assign running_o     = (state_q == ST_RUN) || (state_q == ST_STOP);
    assign sampleValid_o = valid_q;
    assign leftSample_o  = left_q;
    assign rightSample_o = right_q;
    assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Bench for i2s_frame_ctrl: cycle-accurate reference built from frame-time arithmetic,
// directed bus sequences, a capture-path vector table and a randomized soak.
module tb_i2s_frame_ctrl;
    localparam int W = 16;
    localparam int H = 4;
    localparam int FRAME = 4 * W * H;
    localparam int OVR_MAX = 255;

    logic        sclk = 1'b0;
    logic        rst = 1'b0, en = 1'b0, strobe = 1'b0, ready = 1'b0, clr = 1'b0;
    logic [15:0] left = '0, right = '0;
    logic        bclk, ws, rise, running, valid;
    logic [3:0]  idx;
    logic [15:0] lsamp, rsamp;
    logic [7:0]  ovr;

    // Second instance: tiny counter for saturation, fast bus.
    logic        s2_strobe = 1'b0, s2_ready = 1'b0, s2_clr = 1'b0;
    logic [3:0]  s2_left = '0, s2_right = '0;
    logic        s2_bclk, s2_ws, s2_rise, s2_running, s2_valid;
    logic [1:0]  s2_idx;
    logic [3:0]  s2_lsamp, s2_rsamp;
    logic [1:0]  s2_ovr;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: bus phase as elapsed cycles since RUN entry.
    int          m_state = 0;  // 0 idle, 1 run, 2 stop
    int          m_t = 0;
    bit          m_valid = 0;
    logic [15:0] m_left = '0, m_right = '0;
    int          m_ovr = 0;

    always #5 sclk = ~sclk;

    i2s_frame_ctrl #(.WIDTH(16), .HALF_DIV(4), .OVR_W(8)) dut (
        .sclk_i(sclk), .rst_i(rst), .en_i(en), .bclk_o(bclk), .ws_o(ws),
        .bclkRise_o(rise), .bitIdx_o(idx), .running_o(running),
        .frameStrobe_i(strobe), .left_i(left), .right_i(right),
        .sampleValid_o(valid), .sampleReady_i(ready), .leftSample_o(lsamp),
        .rightSample_o(rsamp), .overrun_o(ovr), .clrOvr_i(clr)
    );

    i2s_frame_ctrl #(.WIDTH(4), .HALF_DIV(1), .OVR_W(2)) dut2 (
        .sclk_i(sclk), .rst_i(rst), .en_i(1'b0), .bclk_o(s2_bclk), .ws_o(s2_ws),
        .bclkRise_o(s2_rise), .bitIdx_o(s2_idx), .running_o(s2_running),
        .frameStrobe_i(s2_strobe), .left_i(s2_left), .right_i(s2_right),
        .sampleValid_o(s2_valid), .sampleReady_i(s2_ready), .leftSample_o(s2_lsamp),
        .rightSample_o(s2_rsamp), .overrun_o(s2_ovr), .clrOvr_i(s2_clr)
    );

    typedef struct packed {
        logic        strobe, ready, clr;
        logic [15:0] l, r;
        logic        ev;
        logic [15:0] el, er;
        logic [7:0]  eo;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [48:0] act_pack();
        return {bclk, ws, rise, running, idx, valid, ovr, lsamp, rsamp};
    endfunction

    function automatic logic [48:0] exp_pack();
        logic b, w, r, run;
        logic [3:0] ix;
        b = 0; w = 0; r = 0; run = 0; ix = '0;
        if (m_state != 0) begin
            b   = ((m_t / H) % 2) == 1;
            ix  = 4'((m_t / (2 * H)) % W);
            w   = ((m_t / (2 * H * W)) % 2) == 1;
            r   = (m_t % (2 * H)) == H;
            run = 1;
        end
        return {b, w, r, run, ix, m_valid, 8'(m_ovr), m_left, m_right};
    endfunction

    task automatic model_update();
        bit take, xfer, drop;
        if (!rst) begin
            m_state = 0; m_t = 0; m_valid = 0; m_left = '0; m_right = '0; m_ovr = 0;
        end else begin
            if (m_state == 0) begin
                if (en) begin m_state = 1; m_t = 0; end
            end else if (m_state == 2 && !en && ((m_t + 1) % FRAME == 0)) begin
                m_state = 0; m_t = 0;
            end else begin
                m_t++;
                m_state = en ? 1 : 2;
            end
            take = strobe && (!m_valid || ready);
            xfer = m_valid && ready;
            drop = strobe && m_valid && !ready;
            if (take) begin
                m_left = left; m_right = right; m_valid = 1;
            end else if (xfer) begin
                m_valid = 0;
            end
            if (clr) m_ovr = 0;
            else if (drop && m_ovr < OVR_MAX) m_ovr++;
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        model_update();
        #1;
        chk("model", {15'd0, act_pack()}, {15'd0, exp_pack()});
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last, idle_seen;
        tbl[0] = '{1, 0, 0, 16'h1111, 16'ha111, 1, 16'h1111, 16'ha111, 8'd0};
        tbl[1] = '{1, 0, 0, 16'h2222, 16'ha222, 1, 16'h1111, 16'ha111, 8'd1};
        tbl[2] = '{1, 0, 0, 16'h3333, 16'ha333, 1, 16'h1111, 16'ha111, 8'd2};
        tbl[3] = '{0, 0, 0, 16'hdead, 16'hbeef, 1, 16'h1111, 16'ha111, 8'd2};
        tbl[4] = '{1, 1, 0, 16'h4444, 16'ha444, 1, 16'h4444, 16'ha444, 8'd2};
        tbl[5] = '{0, 1, 0, 16'h0000, 16'h0000, 0, 16'h4444, 16'ha444, 8'd2};
        tbl[6] = '{0, 0, 1, 16'h0000, 16'h0000, 0, 16'h4444, 16'ha444, 8'd0};
        tbl[7] = '{1, 1, 0, 16'h5555, 16'ha555, 1, 16'h5555, 16'ha555, 8'd0};
        tbl[8] = '{1, 0, 1, 16'h6666, 16'ha666, 1, 16'h5555, 16'ha555, 8'd0};
        tbl[9] = '{1, 0, 0, 16'h7777, 16'ha777, 1, 16'h5555, 16'ha555, 8'd1};

        // Reset state
        tick(); tick();
        chk("reset_state", {15'd0, act_pack()}, 64'd0);

        // Free run timing from reset release
        rst = 1; en = 1;
        tick();
        chk("run_entry", {63'd0, running}, 64'd1);
        n = 0;
        while (!rise && n < 50) begin tick(); n++; end
        chk("first_rise", n, 4);
        tick(); last = 1;
        while (!rise && last < 50) begin tick(); last++; end
        chk("bclk_period", last, 8);
        n = n + last;
        while (!ws && n < 400) begin tick(); n++; end
        chk("ws_rise_at", n, 128);
        while (ws && n < 600) begin tick(); n++; end
        chk("frame_len", n, 256);

        // Graceful stop at bit 5 of the left slot
        n = 0;
        while (!(ws == 0 && idx == 5) && n < 300) begin tick(); n++; end
        chk("stop_point", n, 40);
        en = 0;
        n = 0;
        while (running && n < 400) begin tick(); n++; end
        chk("stop_len", n, 216);
        chk("idle_bus", {58'd0, bclk, ws, idx}, 64'd0);
        repeat (5) tick();

        // Stop cancel: bclk keeps an 8-cycle period, never idles
        en = 1;
        last = -1; idle_seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (i == 150) en = 0;
            if (i == 160) en = 1;
            tick();
            if (rise) begin
                if (last >= 0) chk("cancel_period", i - last, 8);
                last = i;
            end
            if (!running) idle_seen = 1;
        end
        chk("cancel_no_idle", idle_seen, 0);

        // Reset mid-frame at right-slot bit 9 with a frame held
        strobe = 1; left = 16'habcd; right = 16'h1234;
        tick();
        strobe = 0;
        n = 0;
        while (!(ws == 1 && idx == 9) && n < 600) begin tick(); n++; end
        chk("rst_point", {62'd0, ws, valid}, 64'd3);
        rst = 0;
        tick();
        chk("rst_mid_all", {15'd0, act_pack()}, 64'd0);
        rst = 1;
        tick();
        chk("restart", {57'd0, running, ws, bclk, idx}, {57'd0, 7'b1000000});

        // Capture path vector table
        for (int i = 0; i < 10; i++) begin
            strobe = tbl[i].strobe; ready = tbl[i].ready; clr = tbl[i].clr;
            left = tbl[i].l; right = tbl[i].r;
            tick();
            chk($sformatf("table[%0d]", i), {15'd0, valid, lsamp, rsamp, ovr},
                {15'd0, tbl[i].ev, tbl[i].el, tbl[i].er, tbl[i].eo});
        end
        strobe = 0; ready = 0; clr = 0;

        // Saturation and clear on the 2-bit counter
        s2_strobe = 1; s2_left = 4'h9; s2_right = 4'h6;
        tick();
        chk("sat_capture", {60'd0, s2_valid, s2_lsamp[2:0]}, 64'h9);
        for (int k = 1; k <= 5; k++) begin
            s2_left = 4'(k);
            tick();
            chk($sformatf("sat_drop%0d", k), {60'd0, s2_ovr, s2_lsamp[1:0]},
                {60'd0, 2'((k > 3) ? 3 : k), 2'b01});
        end
        s2_clr = 1;
        tick();
        chk("sat_clear", {62'd0, s2_ovr}, 64'd0);
        s2_clr = 0; s2_strobe = 0;

        // Randomized soak against the model
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 799) != 0);
            if (en ? ($urandom_range(0, 127) == 0) : ($urandom_range(0, 399) == 0)) en = ~en;
            strobe = ($urandom_range(0, 7) == 0);
            ready  = $urandom_range(0, 1) == 1;
            clr    = ($urandom_range(0, 31) == 0);
            left   = 16'($urandom);
            right  = 16'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
